vga_scanout: RTL and testbench

- Read-side consumer of the dual-ported VRAM. Generates 800x600@60 Hz VGA timing from a pixel clock enable.
- Issues the linear VRAM read address for each visible pixel.
- Realigns sync and blanking to the 1-cycle VRAM read latency.
- Drives amber (#FFBF00) or black RGB to the DAC/pins.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_timing.sv | 81 ++++++++
 rtl/vga_scanout.sv | 125 ++++++++++++
 tb/tb_vga_scanout.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and pixel types for the VGA scan-out path.
// The optional checkerboard source is enabled with VGA_TEST_PATTERN_EN.
package vga_pkg;

  localparam int H_VISIBLE = 800;
  localparam int H_FRONT   = 40;
  localparam int H_SYNC    = 128;
  localparam int H_BACK    = 88;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 600;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 4;
  localparam int V_BACK    = 23;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic SYNC_ACTIVE = 1'b1;
  localparam int   ADDR_W      = 20;

  // Wide enough for both counters at the default timing.
  localparam int CNT_W = 11;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t AMBER_RGB = 24'hFFBF00;

endpackage

// File: rtl/vga_timing.sv
// Stage-0 raster counters: position, visible/sync regions and the frame_start pulse.
// Part of vga_scanout; VGA_TEST_PATTERN_EN does not change this block.
module vga_timing #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pix_ce_i,
  output logic [vga_pkg::CNT_W-1:0] h_cnt_o,
  output logic [vga_pkg::CNT_W-1:0] v_cnt_o,
  output logic                     vis_o,
  output logic                     hs_o,
  output logic                     vs_o,
  output logic                     frame_end_o,
  output logic                     frame_start_o
);
  import vga_pkg::CNT_W;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             fs_q, fs_d;
  logic             line_end;
  logic             frame_end;

  always_comb begin
    line_end  = (h_cnt_q == H_LAST);
    frame_end = line_end && (v_cnt_q == V_LAST);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (pix_ce_i) begin
      if (line_end) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
    // Only a pixel-enable cycle at the origin produces the pulse, so it never stretches.
    fs_d = pix_ce_i && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      fs_q    <= fs_d;
    end
  end

  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;
  assign vis_o         = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hs_o          = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
  assign vs_o          = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
  assign frame_end_o   = frame_end;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_scanout.sv
// VRAM read-side scan-out: linear read address, 2-stage sync/pixel realignment, amber/black RGB.
// Define VGA_TEST_PATTERN_EN to add test_mode, which swaps VRAM data for a checkerboard.
module vga_scanout #(
  parameter int   H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int   H_FRONT     = vga_pkg::H_FRONT,
  parameter int   H_SYNC      = vga_pkg::H_SYNC,
  parameter int   H_BACK      = vga_pkg::H_BACK,
  parameter int   V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int   V_FRONT     = vga_pkg::V_FRONT,
  parameter int   V_SYNC      = vga_pkg::V_SYNC,
  parameter int   V_BACK      = vga_pkg::V_BACK,
  parameter logic SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE,
  parameter int   ADDR_W      = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  input  logic              vram_data,
  output logic [ADDR_W-1:0] raddr,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [23:0]       rgb,
  output logic              frame_start
);
  import vga_pkg::CNT_W;
  import vga_pkg::rgb_t;
  import vga_pkg::AMBER_RGB;

  localparam logic [CNT_W-1:0] H_VIS_LAST = CNT_W'(H_VISIBLE - 1);
  localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             vis0, hs0, vs0, frame_end;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_ce_i      (pix_ce),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .vis_o         (vis0),
    .hs_o          (hs0),
    .vs_o          (vs0),
    .frame_end_o   (frame_end),
    .frame_start_o (frame_start)
  );

  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              last_vis;
  logic              vis1_q, hs1_q, vs1_q, chk1_q, chk0;
  logic              de_q, hsync_q, vsync_q;
  rgb_t              rgb_q, rgb_d;
  logic              pix_src;

  always_comb begin
    last_vis = (h_cnt == H_VIS_LAST) && (v_cnt == V_VIS_LAST);
    raddr_d  = raddr_q;
    // The last visible pixel does not advance, so blanking holds the final address.
    if (pix_ce) begin
      if (frame_end) begin
        raddr_d = '0;
      end else if (vis0 && !last_vis) begin
        raddr_d = raddr_q + 1'b1;
      end
    end
  end

  assign chk0 = h_cnt[3] ^ v_cnt[3];

`ifdef VGA_TEST_PATTERN_EN
  assign pix_src = test_mode ? chk1_q : vram_data;
`else
  assign pix_src = vram_data;
`endif

  always_comb begin
    rgb_d = (vis1_q && pix_src) ? AMBER_RGB : rgb_t'(24'h000000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q <= '0;
      vis1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      chk1_q  <= 1'b0;
      de_q    <= 1'b0;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      rgb_q   <= '0;
    end else begin
      raddr_q <= raddr_d;
      if (pix_ce) begin
        vis1_q  <= vis0;
        hs1_q   <= hs0;
        vs1_q   <= vs0;
        chk1_q  <= chk0;
        de_q    <= vis1_q;
        hsync_q <= hs1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_q <= vs1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        rgb_q   <= rgb_d;
      end
    end
  end

  assign raddr = raddr_q;
  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign rgb   = rgb_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: a full-timing instance for line-level checks and a
// reduced-timing instance (16x13 raster, 8x6 visible) for frame-level checks.
module tb_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic pix_ce = 1'b0;

  logic        vram_l = 1'b0, vram_s = 1'b0;
  logic [19:0] raddr_l, raddr_s;
  logic        hsync_l, vsync_l, de_l, fs_l;
  logic        hsync_s, vsync_s, de_s, fs_s;
  logic [23:0] rgb_l, rgb_s;

  vga_scanout u_dut_l (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_ce      (pix_ce),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode   (1'b0),
`endif
    .vram_data   (vram_l),
    .raddr       (raddr_l),
    .hsync       (hsync_l),
    .vsync       (vsync_l),
    .de          (de_l),
    .rgb         (rgb_l),
    .frame_start (fs_l)
  );

  vga_scanout #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (4), .V_BACK (2)
  ) u_dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_ce      (pix_ce),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode   (1'b0),
`endif
    .vram_data   (vram_s),
    .raddr       (raddr_s),
    .hsync       (hsync_s),
    .vsync       (vsync_s),
    .de          (de_s),
    .rgb         (rgb_s),
    .frame_start (fs_s)
  );

  // VRAM models: one lit pixel at (5,1) in each raster, 1-clk read latency.
  always @(posedge clk) begin
    vram_l <= (raddr_l == 20'd805);
    vram_s <= (raddr_s == 20'd13);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    pix_ce = 1'b0;
    repeat (3) tick();
    rst_n  = 1'b1;
    pix_ce = 1'b1;
  endtask

  int de_rise, hs_rise, de_cnt, hs_cnt, vs_cnt, de_run, de_max, hs_run, hs_max;
  int amber_cnt, amber_at, amber_de;
  logic [23:0] amber_rgb;
  logic prev_de, prev_hs, prev_fs;
  int fs_cnt, fs_first, fs_second, fs_adj, vs_run, vs_max, raddr_max, amb_s, amb_s_first;

  initial begin
    rst_n  = 1'b0;
    pix_ce = 1'b0;
    repeat (3) tick();
    check_eq("rst_raddr", raddr_l, 0);
    check_eq("rst_raddr_s", raddr_s, 0);
    check_eq("rst_hsync", hsync_l, 0);
    check_eq("rst_vsync", vsync_l, 0);
    check_eq("rst_de", de_l, 0);
    check_eq("rst_rgb", rgb_l, 0);
    check_eq("rst_fs", fs_l, 0);

    // Full timing, pix_ce every clk, three lines.
    rst_n = 1'b1;
    pix_ce = 1'b1;
    de_rise = 0; hs_rise = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    de_run = 0; de_max = 0; hs_run = 0; hs_max = 0;
    amber_cnt = 0; amber_at = 0; amber_de = 0; amber_rgb = '0;
    prev_de = 1'b0; prev_hs = 1'b0;
    for (int n = 1; n <= 3 * 1056; n++) begin
      tick();
      if (n == 1)    check_eq("fs_first", fs_l, 1);
      if (n == 2)    check_eq("fs_width", fs_l, 0);
      if (n == 1056) check_eq("raddr_0_1", raddr_l, 800);
      if (n == 1061) check_eq("raddr_5_1", raddr_l, 805);
      if (de_l && !prev_de && de_rise == 0) de_rise = n;
      if (hsync_l && !prev_hs && hs_rise == 0) hs_rise = n;
      de_cnt += int'(de_l);
      hs_cnt += int'(hsync_l);
      vs_cnt += int'(vsync_l);
      de_run = de_l ? de_run + 1 : 0;
      hs_run = hsync_l ? hs_run + 1 : 0;
      if (de_run > de_max) de_max = de_run;
      if (hs_run > hs_max) hs_max = hs_run;
      if (rgb_l != 24'h0) begin
        amber_cnt++;
        amber_at  = n;
        amber_rgb = rgb_l;
        amber_de  = int'(de_l);
      end
      prev_de = de_l;
      prev_hs = hsync_l;
    end
    check_eq("de_rise", de_rise, 2);
    check_eq("hs_offset", hs_rise - de_rise, 840);
    check_eq("hs_width", hs_max, 128);
    check_eq("de_width", de_max, 800);
    check_eq("de_total", de_cnt, 2400);
    check_eq("hs_total", hs_cnt, 384);
    check_eq("vs_idle", vs_cnt, 0);
    check_eq("amber_cnt", amber_cnt, 1);
    check_eq("amber_at", amber_at, 1063);
    check_eq("amber_rgb", amber_rgb, 24'hFFBF00);
    check_eq("amber_de", amber_de, 1);

    // Reduced timing, full rate: frame period 208 clks, last address 47.
    apply_reset();
    fs_cnt = 0; fs_first = 0; fs_second = 0; fs_adj = 0; de_cnt = 0;
    vs_run = 0; vs_max = 0; raddr_max = 0; amb_s = 0; amb_s_first = 0;
    prev_fs = 1'b0;
    for (int n = 1; n <= 640; n++) begin
      tick();
      if (fs_s) begin
        fs_cnt++;
        if (fs_first == 0) fs_first = n;
        else if (fs_second == 0) fs_second = n;
        if (prev_fs) fs_adj++;
      end
      prev_fs = fs_s;
      if (n <= 208) de_cnt += int'(de_s);
      vs_run = vsync_s ? vs_run + 1 : 0;
      if (vs_run > vs_max) vs_max = vs_run;
      if (int'(raddr_s) > raddr_max) raddr_max = int'(raddr_s);
      if (rgb_s != 24'h0) begin
        amb_s++;
        if (amb_s_first == 0) amb_s_first = n;
      end
      if (n == 87)  check_eq("s_raddr_last", raddr_s, 47);
      if (n == 207) check_eq("s_raddr_hold", raddr_s, 47);
      if (n == 208) check_eq("s_raddr_wrap", raddr_s, 0);
    end
    check_eq("s_fs_first", fs_first, 1);
    check_eq("s_fs_period", fs_second - fs_first, 208);
    check_eq("s_fs_cnt", fs_cnt, 4);
    check_eq("s_fs_adj", fs_adj, 0);
    check_eq("s_de_frame", de_cnt, 48);
    check_eq("s_vs_width", vs_max, 64);
    check_eq("s_raddr_max", raddr_max, 47);
    check_eq("s_amber_cnt", amb_s, 3);
    check_eq("s_amber_first", amb_s_first, 23);

    // Reduced timing, pix_ce every other clk: everything stretches by 2.
    apply_reset();
    fs_cnt = 0; fs_first = 0; fs_second = 0; fs_adj = 0; de_cnt = 0;
    vs_run = 0; vs_max = 0;
    prev_fs = 1'b0;
    for (int n = 1; n <= 900; n++) begin
      pix_ce = (n % 2 == 1);
      tick();
      if (fs_s) begin
        fs_cnt++;
        if (fs_first == 0) fs_first = n;
        else if (fs_second == 0) fs_second = n;
        if (prev_fs) fs_adj++;
      end
      prev_fs = fs_s;
      if (n <= 416) de_cnt += int'(de_s);
      vs_run = vsync_s ? vs_run + 1 : 0;
      if (vs_run > vs_max) vs_max = vs_run;
      if (n == 172) check_eq("h_raddr_a", raddr_s, 46);
      if (n == 173) check_eq("h_raddr_b", raddr_s, 47);
    end
    check_eq("h_fs_first", fs_first, 1);
    check_eq("h_fs_period", fs_second - fs_first, 416);
    check_eq("h_fs_cnt", fs_cnt, 3);
    check_eq("h_fs_adj", fs_adj, 0);
    check_eq("h_de_frame", de_cnt, 96);
    check_eq("h_vs_width", vs_max, 128);

    // Mid-frame reset: small raster at (4,3), large at (52,0).
    apply_reset();
    for (int n = 1; n <= 52; n++) tick();
    check_eq("m_raddr_s", raddr_s, 28);
    check_eq("m_raddr_l", raddr_l, 52);
    check_eq("m_de_s", de_s, 1);
    rst_n = 1'b0;
    #1;
    check_eq("m_async_de", de_s, 0);
    check_eq("m_async_raddr_s", raddr_s, 0);
    check_eq("m_async_raddr_l", raddr_l, 0);
    repeat (3) tick();
    check_eq("m_rst_fs", fs_s, 0);
    check_eq("m_rst_hsync", hsync_l, 0);
    rst_n = 1'b1;
    tick();
    check_eq("m_fs_restart", fs_s, 1);
    check_eq("m_raddr_restart", raddr_s, 1);
    tick();
    check_eq("m_de_restart", de_s, 1);
    check_eq("m_fs_single", fs_s, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
